// File: rtl/hamming_stream_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : hamming_stream_encoder_if
// Description : Streaming bus for hamming_stream_encoder: input word channel,
//               output codeword channel and the accepted-word counter.
//               Codeword width follows the HAM_SECDED_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
interface hamming_stream_encoder_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
);
    // Smallest r with 2^r >= dw + r + 1
    function automatic int calc_par_w(input int dw);
        int r;
        r = 1;
        while ((1 << r) < (dw + r + 1)) r++;
        return r;
    endfunction

    localparam int PAR_W = calc_par_w(DATA_W);
`ifdef HAM_SECDED_EN
    localparam int CODE_W = DATA_W + PAR_W + 1;
`else
    localparam int CODE_W = DATA_W + PAR_W;
`endif

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_odd;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic [CNT_W-1:0]  word_count;

    modport master (
        output in_valid, in_data, in_odd, out_ready,
        input  in_ready, out_valid, out_code, word_count
    );

    modport slave (
        input  in_valid, in_data, in_odd, out_ready,
        output in_ready, out_valid, out_code, word_count
    );
endinterface
`default_nettype wire

// File: rtl/hamming_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : hamming_stream_encoder
// Description : Parametrised Hamming encoder (DATA_W = 1..57) with per-word
//               even/odd parity, valid/ready streaming through a 2-entry skid
//               buffer (registered in_ready) and a saturating word counter.
//               Define HAM_SECDED_EN to append an overall-parity MSB
//               (extended Hamming, SEC-DED).
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_stream_encoder #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    hamming_stream_encoder_if.slave bus
);
    function automatic int calc_par_w(input int dw);
        int r;
        r = 1;
        while ((1 << r) < (dw + r + 1)) r++;
        return r;
    endfunction

    function automatic logic is_pow2(input int v);
        return ((v & (v - 1)) == 0);
    endfunction

    // Codeword position (1-based) of data bit idx: idx-th non-power-of-two
    function automatic int data_pos(input int idx);
        int p;
        int cnt;
        p   = 0;
        cnt = -1;
        while (cnt < idx) begin
            p++;
            if (!is_pow2(p)) cnt++;
        end
        return p;
    endfunction

    localparam int PAR_W = calc_par_w(DATA_W);
    localparam int N_POS = DATA_W + PAR_W;
`ifdef HAM_SECDED_EN
    localparam int CODE_W = N_POS + 1;
`else
    localparam int CODE_W = N_POS;
`endif

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [CODE_W-1:0]   r_main;
    logic [CODE_W-1:0]   r_skid;
    logic [CNT_W-1:0]    r_count;

    logic [N_POS-1:0]    w_place;
    logic [N_POS-1:0]    w_ham;
    logic                w_par;
    logic [CODE_W-1:0]   w_code;
    logic                w_accept;
    logic                w_pop;
    logic                w_ld_main_in;
    logic                w_ld_main_skid;
    logic                w_ld_skid;

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_pop    = r_out_valid && bus.out_ready;

    // Scatter data bits into the non-power-of-two positions, parity slots zero
    always_comb begin
        w_place = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_place[data_pos(i) - 1] = bus.in_data[i];
        end
    end

    // Fill each parity slot 2^k with the XOR of covered data bits and polarity
    always_comb begin
        w_ham = w_place;
        w_par = 1'b0;
        for (int k = 0; k < PAR_W; k++) begin
            w_par = bus.in_odd;
            for (int p = 1; p <= N_POS; p++) begin
                if (p[k] && !is_pow2(p)) w_par = w_par ^ w_place[p - 1];
            end
            w_ham[(1 << k) - 1] = w_par;
        end
    end

`ifdef HAM_SECDED_EN
    // Overall parity over the whole Hamming word, with the same polarity
    assign w_code = {(^w_ham) ^ bus.in_odd, w_ham};
`else
    assign w_code = w_ham;
`endif

    // Skid-buffer occupancy: next state and which register loads what
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt  = ST_ONE;
                    w_ld_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_ld_main_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_TWO;
                    w_ld_skid   = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a pop can happen
                if (w_pop) begin
                    w_state_nxt    = ST_ONE;
                    w_ld_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // State register with registered handshake flags derived from next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Codeword storage; main holds its value while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main_skid) begin
                r_main <= r_skid;
            end else if (w_ld_main_in) begin
                r_main <= w_code;
            end
            if (w_ld_skid) begin
                r_skid <= w_code;
            end
        end
    end

    // Saturating count of accepted words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_accept && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_code   = r_main;
    assign bus.word_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_hamming_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_stream_encoder
// Description : Self-checking bench for hamming_stream_encoder. Two instances:
//               DATA_W=4/CNT_W=4 (directed vectors, backpressure, saturation,
//               reset) and DATA_W=11/CNT_W=16 (random streaming). Honours
//               HAM_SECDED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_stream_encoder;
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hamming_stream_encoder_if #(.DATA_W(4),  .CNT_W(4))  bus4 ();
    hamming_stream_encoder_if #(.DATA_W(11), .CNT_W(16)) bus11 ();

    hamming_stream_encoder #(.DATA_W(4), .CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    hamming_stream_encoder #(.DATA_W(11), .CNT_W(16)) u_dut11 (
        .clk (clk),
        .rst (rst),
        .bus (bus11)
    );

    int          n_cmp;
    int          n_err;
    int          pops11;
    int          exp_cnt4;
    logic [63:0] q4  [$];
    logic [63:0] q11 [$];
    logic [3:0]  td   [4];
    logic        todd [4];
    logic [63:0] texp [4];

    // Reference: syndrome of data positions gives the parity bits directly
    function automatic logic [63:0] ref_code(input int dw, input logic [63:0] d, input logic odd);
        int          pw;
        int          n;
        int          di;
        logic [63:0] c;
        logic [7:0]  syn;
        pw = 1;
        while ((1 << pw) < (dw + pw + 1)) pw++;
        n   = dw + pw;
        c   = '0;
        syn = '0;
        di  = 0;
        for (int pos = 1; pos <= n; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos - 1] = d[di];
                if (d[di]) syn = syn ^ pos[7:0];
                di++;
            end
        end
        for (int k = 0; k < pw; k++) c[(1 << k) - 1] = syn[k] ^ odd;
`ifdef HAM_SECDED_EN
        c[n] = (^c) ^ odd;
`endif
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [3:0] d, input logic odd);
        int guard;
        guard = 0;
        bus4.in_valid = 1'b1;
        bus4.in_data  = d;
        bus4.in_odd   = odd;
        while (!bus4.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!bus4.in_ready) begin
            check("dut4_accept_timeout", {63'd0, bus4.in_ready}, 64'd1);
        end else begin
            q4.push_back(ref_code(4, {60'd0, d}, odd));
            if (exp_cnt4 < 15) exp_cnt4++;
        end
        tick();
        bus4.in_valid = 1'b0;
    endtask

    // Scoreboard: every output handshake pops and compares the oldest expected word
    always @(negedge clk) begin
        logic [63:0] exp;
        if (!rst) begin
            if (bus4.out_valid && bus4.out_ready) begin
                exp = (q4.size() > 0) ? q4.pop_front() : {64{1'bx}};
                check("dut4_code", {57'd0, bus4.out_code}, exp);
            end
            if (bus11.out_valid && bus11.out_ready) begin
                exp = (q11.size() > 0) ? q11.pop_front() : {64{1'bx}};
                check("dut11_code", {49'd0, bus11.out_code}, exp);
                pops11++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] code_a;
        logic [10:0] d11;
        logic        o11;

        n_cmp    = 0;
        n_err    = 0;
        pops11   = 0;
        exp_cnt4 = 0;
        td   = '{4'b1011, 4'b1011, 4'b0000, 4'b0001};
        todd = '{1'b0, 1'b1, 1'b1, 1'b0};
`ifdef HAM_SECDED_EN
        texp = '{64'h55, 64'h5E, 64'h0B, 64'h87};
`else
        texp = '{64'h55, 64'h5E, 64'h0B, 64'h07};
`endif
        rst             = 1'b1;
        bus4.in_valid   = 1'b0;
        bus4.in_data    = '0;
        bus4.in_odd     = 1'b0;
        bus4.out_ready  = 1'b0;
        bus11.in_valid  = 1'b0;
        bus11.in_data   = '0;
        bus11.in_odd    = 1'b0;
        bus11.out_ready = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_in_ready",   {63'd0, bus4.in_ready},   64'd1);
        check("rst_out_valid",  {63'd0, bus4.out_valid},  64'd0);
        check("rst_out_code",   {57'd0, bus4.out_code},   64'd0);
        check("rst_word_count", {60'd0, bus4.word_count}, 64'd0);
        check("rst_in_ready11", {63'd0, bus11.in_ready},  64'd1);
        rst = 1'b0;
        tick();

        // Directed vectors with one-cycle latency
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send4(td[i], todd[i]);
            check("dir_out_valid", {63'd0, bus4.out_valid}, 64'd1);
            check("dir_out_code",  {57'd0, bus4.out_code},  texp[i]);
        end
        tick();
        check("dir_word_count", {60'd0, bus4.word_count}, 64'(exp_cnt4));
        check("dir_drained",    {63'd0, bus4.out_valid},  64'd0);

        // Backpressure: three words offered, only two fit
        bus4.out_ready = 1'b0;
        bus4.in_valid  = 1'b1;
        bus4.in_data   = 4'h3;
        bus4.in_odd    = 1'b0;
        code_a = ref_code(4, 64'h3, 1'b0);
        check("bp_ready_a", {63'd0, bus4.in_ready}, 64'd1);
        q4.push_back(code_a);
        exp_cnt4++;
        tick();
        bus4.in_data = 4'h5;
        bus4.in_odd  = 1'b1;
        check("bp_ready_b", {63'd0, bus4.in_ready}, 64'd1);
        q4.push_back(ref_code(4, 64'h5, 1'b1));
        exp_cnt4++;
        tick();
        bus4.in_data = 4'h9;
        bus4.in_odd  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready_low",  {63'd0, bus4.in_ready},  64'd0);
            check("bp_out_valid",  {63'd0, bus4.out_valid}, 64'd1);
            check("bp_code_stable", {57'd0, bus4.out_code}, code_a);
            tick();
        end
        check("bp_count_two", {60'd0, bus4.word_count}, 64'(exp_cnt4));
        bus4.out_ready = 1'b1;
        tick();
        check("bp_ready_back", {63'd0, bus4.in_ready}, 64'd1);
        q4.push_back(ref_code(4, 64'h9, 1'b0));
        exp_cnt4++;
        tick();
        bus4.in_valid = 1'b0;
        check("bp_count_three", {60'd0, bus4.word_count}, 64'(exp_cnt4));
        repeat (3) tick();
        check("bp_queue_empty", 64'(q4.size()), 64'd0);
        check("bp_drained",     {63'd0, bus4.out_valid}, 64'd0);

        // Counter saturation on the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            send4(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            check("sat_count", {60'd0, bus4.word_count}, 64'(exp_cnt4));
        end
        check("sat_final", {60'd0, bus4.word_count}, 64'hF);
        repeat (2) tick();

        // Continuous random streaming on the 11-bit instance
        bus11.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            d11 = 11'($urandom);
            o11 = 1'($urandom_range(0, 1));
            bus11.in_valid = 1'b1;
            bus11.in_data  = d11;
            bus11.in_odd   = o11;
            check("str_in_ready", {63'd0, bus11.in_ready}, 64'd1);
            q11.push_back(ref_code(11, {53'd0, d11}, o11));
            tick();
            check("str_out_valid", {63'd0, bus11.out_valid}, 64'd1);
        end
        bus11.in_valid = 1'b0;
        repeat (3) tick();
        check("str_pops",       64'(pops11),          64'd1000);
        check("str_queue",      64'(q11.size()),      64'd0);
        check("str_word_count", {48'd0, bus11.word_count}, 64'd1000);

        // Asynchronous reset with both buffers full
        bus4.out_ready = 1'b0;
        send4(4'hA, 1'b0);
        send4(4'h6, 1'b1);
        check("mid_full_ready", {63'd0, bus4.in_ready},  64'd0);
        check("mid_full_valid", {63'd0, bus4.out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, bus4.out_valid},  64'd0);
        check("mid_rst_ready", {63'd0, bus4.in_ready},   64'd1);
        check("mid_rst_count", {60'd0, bus4.word_count}, 64'd0);
        check("mid_rst_code",  {57'd0, bus4.out_code},   64'd0);
        q4.delete();
        exp_cnt4 = 0;
        tick();
        rst = 1'b0;
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_stale", {63'd0, bus4.out_valid}, 64'd0);
        end

        // Recovery after reset
        send4(4'b1011, 1'b0);
        check("post_rst_code",  {57'd0, bus4.out_code},   texp[0]);
        check("post_rst_count", {60'd0, bus4.word_count}, 64'(exp_cnt4));
        repeat (3) tick();
        check("post_rst_queue", 64'(q4.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hamming_stream_encoder.md
# hamming_stream_encoder

Parametrised, pipelined Hamming encoder with a valid/ready streaming interface, per-word even/odd parity selection and a saturating word counter. It generalises the fixed 4-bit/7-bit combinational encoder to any data width from 1 to 57 bits. It registers its output behind a 2-entry skid buffer so it can sit between streaming stages without a combinational ready path. It feeds the channel/error-injection path, with the matching decoder downstream.

## Interface
Parameters:
- DATA_W, 4, data bits per word; legal 1..57.
- PAR_W, derived (localparam), smallest r with 2^r ≥ DATA_W + r + 1 (3 for DATA_W=4, 4 for 11, 6 for 57).
- CODE_W, derived (localparam), DATA_W + PAR_W, plus 1 when HAM_SECDED_EN is defined.
- CNT_W, 16, word-counter width.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset; asynchronous and active-high.
- in_valid, input, 1, in_data/in_odd valid.
- in_ready, output, 1, block accepts a word this cycle; driven from a register.
- in_data, input, DATA_W, data word.
- in_odd, input, 1, 1 = odd parity (all parity bits inverted), 0 = even.
- out_valid, output, 1, out_code valid.
- out_ready, input, 1, downstream accepts.
- out_code, output, CODE_W, encoded codeword.
- word_count, output, CNT_W, number of words accepted since reset; saturating.

## Operation
- Codeword positions 1..DATA_W+PAR_W map to out_code bit (position−1).
- Parity bits sit at power-of-two positions (1, 2, 4, 8, …). Data bits fill the remaining positions in ascending order, in_data[0] first.
- Parity bit at position 2^k = XOR of all data bits whose position has bit k set, then XOR in_odd.
- in_odd is captured with its word. Different words in flight may use different polarities.
- Storage: a main output register plus one skid register, each holding {valid, code}.
- A word is accepted when in_valid && in_ready. The codeword is computed combinationally at the input and stored already encoded.
- On accept:
  - If main is empty, or main is being emptied this cycle (out_valid && out_ready), the word goes to main.
  - Otherwise it goes to skid.
- On out_valid && out_ready: skid moves to main if skid is occupied. Otherwise main empties unless a new word is loaded into it in the same cycle.
- in_ready register = NOT skid occupied (next-state value).
- States: EMPTY (main empty, skid empty), ONE (main full, skid empty), TWO (both full).
  - EMPTY→ONE on accept.
  - ONE→TWO on accept without pop.
  - ONE→EMPTY on pop without accept.
  - ONE stays ONE on simultaneous accept and pop.
  - TWO→ONE on pop. No accept is possible in TWO because in_ready=0.
- word_count increments by 1 on each accept and holds at 2^CNT_W−1.
- out_code and its polarity remain stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=1, out_valid=0, out_code=0, word_count=0, skid empty.
- Reset asserted mid-stream discards both buffered words immediately (asynchronous). Words held at reset are never emitted.
- Latency: a word accepted at edge n appears with out_valid=1 after edge n; 1 cycle.
- Throughput: 1 word/cycle while out_ready=1.
- in_ready deasserts the cycle after the skid fills. It reasserts the cycle after the skid drains, with no bubble on out_valid.
- in_data and in_odd are don't-care when in_valid=0. out_code is don't-care when out_valid=0, but is driven from the register (0 after reset).

## Configuration
- HAM_SECDED_EN defined:
  - CODE_W gains 1 bit at the MSB.
  - The MSB = XOR of all lower code bits, XOR in_odd. This gives an extended Hamming code suitable for SEC-DED.
- HAM_SECDED_EN undefined: plain Hamming code, CODE_W = DATA_W + PAR_W, with no overall parity logic.

## Test plan
- DATA_W=4, even: in_data=4'b1011, in_odd=0 → out_code=7'h55 one cycle later. With in_odd=1 → 7'h5E. in_data=0, in_odd=1 → 7'h0B.
- DATA_W=4 with HAM_SECDED_EN: 4'b1011 even → 8'h55. 4'b1011 odd → 8'h5E. 4'b0001 even → 8'h87.
- Backpressure: out_ready=0 while 3 words are offered → exactly 2 accepted, in_ready=0 from the cycle after the 2nd accept. Raise out_ready → words emerge in order, then in_ready=1. No loss or duplication; word_count=3 once the third word is accepted.
- Continuous streaming: DATA_W=11, 1000 random words with in_valid=out_ready=1 → one codeword per cycle, matching the reference model, with a per-word random in_odd.
- Reset mid-operation: both buffers full, assert rst for 1 cycle → out_valid=0, in_ready=1, word_count=0 immediately; no stale word emitted afterwards.
- Counter saturation: CNT_W=4, 20 accepts → word_count stops at 4'hF.
